// File: rtl/unidad_control_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU-op codes, state encodings.
package unidad_control_pkg;

   // Default opcode encodings
   localparam int unsigned OP_R_DEF    = 0;
   localparam int unsigned OP_LW_DEF   = 35;
   localparam int unsigned OP_SW_DEF   = 43;
   localparam int unsigned OP_BEQ_DEF  = 4;
   localparam int unsigned OP_ADDI_DEF = 8;
   localparam int unsigned OP_J_DEF    = 2;

   // ALU-op codes; wider ALUOP ports are zero-extended
   localparam logic [1:0] AluAdd   = 2'd0;
   localparam logic [1:0] AluSub   = 2'd1;
   localparam logic [1:0] AluFunct = 2'd2;

   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StIf   = 4'd1,
      StId   = 4'd2,
      StEx   = 4'd3,
      StMem  = 4'd4,
      StWb   = 4'd5,
      StTrap = 4'd6
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory ready handshake and flags a timeout.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic memReady,
   output logic expired
);

   logic [7:0] count_q, count_d;

   // Count while waiting; clear on ready or whenever the owner is not waiting
   always_comb begin
      count_d = '0;
      if (active && !memReady) begin
         count_d = count_q + 8'd1;
      end
   end

   // Expires in the cycle the count would reach TIMEOUT with ready still low;
   // a ready in that same cycle wins.
   assign expired = active && !memReady && (({1'b0, count_q} + 9'd1) == 9'(TIMEOUT));

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle main control unit: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
module unidad_control_multiciclo
   import unidad_control_pkg::*;
#(
   parameter int unsigned OP_W    = 6,
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned OP_R    = OP_R_DEF,
   parameter int unsigned OP_LW   = OP_LW_DEF,
   parameter int unsigned OP_SW   = OP_SW_DEF,
   parameter int unsigned OP_BEQ  = OP_BEQ_DEF,
   parameter int unsigned OP_ADDI = OP_ADDI_DEF,
   parameter int unsigned OP_J    = OP_J_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [OP_W-1:0]    inst,
   input  logic               mem_ready,
   output logic               RegDst,
   output logic               Branch,
   output logic               MemRead,
   output logic               MemToRg,
   output logic               MemToWrite,
   output logic               ALUSrc,
   output logic               RegWrite,
   output logic [ALUOP_W-1:0] ALUOP,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               Jump,
   output logic               inst_done,
   output logic               err,
   output logic [3:0]         state_o
);

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic            waitActive, waitExpired;
   logic            isR, isLw, isSw, isBeq, isAddi, isJ;
   logic            instLegal;
   logic [1:0]      aluCode;

   assign isR    = (op_q == OP_W'(OP_R));
   assign isLw   = (op_q == OP_W'(OP_LW));
   assign isSw   = (op_q == OP_W'(OP_SW));
   assign isBeq  = (op_q == OP_W'(OP_BEQ));
   assign isAddi = (op_q == OP_W'(OP_ADDI));
   assign isJ    = (op_q == OP_W'(OP_J));

   assign instLegal = (inst == OP_W'(OP_R))   || (inst == OP_W'(OP_LW)) ||
                      (inst == OP_W'(OP_SW))  || (inst == OP_W'(OP_BEQ)) ||
                      (inst == OP_W'(OP_ADDI)) || (inst == OP_W'(OP_J));

   assign waitActive = (state_q == StIf) || (state_q == StMem);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .active   (waitActive),
      .memReady (mem_ready),
      .expired  (waitExpired)
   );

   // State and latched opcode registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Next-state logic; en is only consulted at IDLE and instruction boundaries
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         StIdle: if (en) state_d = StIf;
         StIf: begin
            if (mem_ready)        state_d = StId;
            else if (waitExpired) state_d = StTrap;
         end
         StId: begin
            op_d    = inst;
            state_d = instLegal ? StEx : StTrap;
         end
         StEx: begin
            if (isBeq || isJ)     state_d = en ? StIf : StIdle;
            else if (isLw || isSw) state_d = StMem;
            else                  state_d = StWb;
         end
         StMem: begin
            if (mem_ready)        state_d = isLw ? StWb : (en ? StIf : StIdle);
            else if (waitExpired) state_d = StTrap;
         end
         StWb:   state_d = en ? StIf : StIdle;
         StTrap: state_d = StTrap;
         default: state_d = StIdle;
      endcase
   end

   // Output decode from state and latched opcode (mem_ready qualifies handshake strobes)
   always_comb begin
      RegDst     = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemToRg    = 1'b0;
      MemToWrite = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      Jump       = 1'b0;
      inst_done  = 1'b0;
      err        = 1'b0;
      aluCode    = AluAdd;
      case (state_q)
         StIf: begin
            MemRead = 1'b1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         StEx: begin
            if (isR) begin
               aluCode = AluFunct;
            end else if (isLw || isSw || isAddi) begin
               ALUSrc = 1'b1;
            end else if (isBeq) begin
               aluCode   = AluSub;
               Branch    = 1'b1;
               inst_done = 1'b1;
            end else if (isJ) begin
               Jump      = 1'b1;
               PCWrite   = 1'b1;
               inst_done = 1'b1;
            end
         end
         StMem: begin
            MemRead    = isLw;
            MemToWrite = isSw;
            inst_done  = isSw && mem_ready;
         end
         StWb: begin
            RegWrite  = 1'b1;
            inst_done = 1'b1;
            RegDst    = isR;
            MemToRg   = isLw;
         end
         StTrap: err = 1'b1;
         default: ;
      endcase
   end

   assign ALUOP   = ALUOP_W'(aluCode);
   assign state_o = state_q;

endmodule
